// File: rtl/sram_sdp_param_if.sv
// Request/response bundle for the simple-dual-port SRAM.
// The master side issues writes, reads and clears; the slave side returns read results and readiness.
interface sram_sdp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              ready;

  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, ready
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, ready
  );
endinterface

// File: rtl/sram_sdp_param.sv
// Parametrised simple-dual-port synchronous SRAM with registered read latency,
// read-during-write policy, out-of-range flag and a self-clearing init sweep.
module sram_sdp_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_sdp_param_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] init_ptr, next_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok, rd_ok, wr_acc, rd_acc;
  logic [DATA_W-1:0] rd_word;

  logic              s1_valid, s1_err;
  logic [DATA_W-1:0] s1_data;

  assign wr_ok  = {1'b0, bus.wr_addr} < DEPTH_X;
  assign rd_ok  = {1'b0, bus.rd_addr} < DEPTH_X;
  assign wr_acc = (state == IDLE) && !bus.clr && bus.wr_en && wr_ok;
  assign rd_acc = (state == IDLE) && !bus.clr && bus.rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= next_state;
      init_ptr <= next_ptr;
    end
  end

  // INIT sweeps one word per edge and hands over on the edge that clears the last word.
  always_comb begin
    next_state = state;
    next_ptr   = init_ptr;
    case (state)
      INIT: begin
        if (init_ptr == LAST_PTR) begin
          next_state = IDLE;
          next_ptr   = '0;
        end else begin
          next_ptr = init_ptr + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr) begin
          next_state = INIT;
          next_ptr   = '0;
        end
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_ptr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // With RDW_MODE=1 a same-address write bypasses the array into the read result.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if ((RDW_MODE == 1) && wr_acc && (bus.wr_addr == bus.rd_addr)) begin
        rd_word = bus.wr_data;
      end else begin
        rd_word = mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      s1_err   <= rd_acc && !rd_ok;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s2_valid, s2_err;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign bus.rd_valid = s2_valid;
      assign bus.rd_err   = s2_err;
      assign bus.rd_data  = s2_data;
    end else begin : g_lat1
      assign bus.rd_valid = s1_valid;
      assign bus.rd_err   = s1_err;
      assign bus.rd_data  = s1_data;
    end
  endgenerate

  assign bus.ready = (state == IDLE);

endmodule

// File: tb/tb_sram_sdp_param.sv
// Drives two SRAM instances (READ_LAT=1/RDW old-data and READ_LAT=2/RDW new-data) with shared
// stimulus and checks both every cycle against a word-level model of the memory.
module tb_sram_sdp_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  typedef struct {
    int             due;
    logic           err;
    logic [DATA_W-1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  sram_sdp_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  sram_sdp_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

  sram_sdp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1), .RDW_MODE(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  sram_sdp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(2), .RDW_MODE(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  always #5 clk = ~clk;

  // Model state: array contents, edges left in the init sweep, and pending read results.
  logic [DATA_W-1:0] mem_m [DEPTH];
  int                init_left = DEPTH;
  int                cyc = 0;
  res_t              q_a[$];
  res_t              q_b[$];
  logic [DATA_W-1:0] hold_a = '0;
  logic [DATA_W-1:0] hold_b = '0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic res_t model_read(input int lat, input bit new_data);
    res_t r;
    r.due  = cyc + lat - 1;
    r.err  = 1'b0;
    r.data = '0;
    if (int'(bus_a.rd_addr) >= DEPTH) begin
      r.err = 1'b1;
    end else if (new_data && bus_a.wr_en && bus_a.wr_addr == bus_a.rd_addr) begin
      r.data = bus_a.wr_data;
    end else begin
      r.data = mem_m[bus_a.rd_addr];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      hold_a = '0;
      hold_b = '0;
    end else begin
      cyc++;
      if (init_left > 0) begin
        init_left--;
      end else if (bus_a.clr) begin
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end else begin
        if (bus_a.rd_en) begin
          q_a.push_back(model_read(1, 1'b0));
          q_b.push_back(model_read(2, 1'b1));
        end
        if (bus_a.wr_en && int'(bus_a.wr_addr) < DEPTH) mem_m[bus_a.wr_addr] = bus_a.wr_data;
      end
    end
  end

  always @(negedge clk) begin
    logic              ev, ee;
    logic [DATA_W-1:0] ed;
    logic              er;
    er = rst_n && (init_left == 0);

    ev = 1'b0; ee = 1'b0; ed = hold_a;
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      ev = 1'b1; ee = q_a[0].err; ed = q_a[0].data; hold_a = ed;
      void'(q_a.pop_front());
    end
    check_output("a_valid", bus_a.rd_valid, ev);
    check_output("a_err", bus_a.rd_err, ee);
    check_output("a_data", bus_a.rd_data, ed);
    check_output("a_ready", bus_a.ready, er);

    ev = 1'b0; ee = 1'b0; ed = hold_b;
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      ev = 1'b1; ee = q_b[0].err; ed = q_b[0].data; hold_b = ed;
      void'(q_b.pop_front());
    end
    check_output("b_valid", bus_b.rd_valid, ev);
    check_output("b_err", bus_b.rd_err, ee);
    check_output("b_data", bus_b.rd_data, ed);
    check_output("b_ready", bus_b.ready, er);
  end

  task automatic set_inputs(input logic c, input logic we, input logic [ADDR_W-1:0] wa,
                            input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] ra);
    bus_a.clr = c;  bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd;
    bus_a.rd_en = re; bus_a.rd_addr = ra;
    bus_b.clr = c;  bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd;
    bus_b.rd_en = re; bus_b.rd_addr = ra;
  endtask

  task automatic apply_stimulus(input logic c, input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] ra);
    set_inputs(c, we, wa, wd, re, ra);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Counts sampled cycles with ready low, starting from the current one.
  task automatic count_not_ready(input string name, input int expected);
    int lows = 0;
    while (!bus_a.ready && lows < 100) begin
      lows++;
      @(negedge clk);
    end
    check_output(name, lows, expected);
  endtask

  initial begin
    set_inputs(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    count_not_ready("ready_after_reset", DEPTH);

    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(i));
      check_output("init_zero_valid", bus_a.rd_valid, 1'b1);
      check_output("init_zero_data", bus_a.rd_data, 8'h00);
    end
    idle_cycle();

    apply_stimulus(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    check_output("lat1_read_a5", bus_a.rd_data, 8'hA5);
    check_output("lat2_not_yet", bus_b.rd_valid, 1'b0);
    idle_cycle();
    check_output("lat2_read_a5", bus_b.rd_data, 8'hA5);

    apply_stimulus(1'b0, 1'b1, 4'd3, 8'h3C, 1'b1, 4'd3);
    check_output("rdw_old", bus_a.rd_data, 8'hA5);
    idle_cycle();
    check_output("rdw_new", bus_b.rd_data, 8'h3C);
    check_output("model_mem3", mem_m[3], 8'h3C);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    check_output("reread_a", bus_a.rd_data, 8'h3C);
    idle_cycle();
    check_output("reread_b", bus_b.rd_data, 8'h3C);

    apply_stimulus(1'b0, 1'b1, 4'd12, 8'hFF, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 4'd13, 8'hFF, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd12);
    check_output("oor_valid", bus_a.rd_valid, 1'b1);
    check_output("oor_err", bus_a.rd_err, 1'b1);
    check_output("oor_data", bus_a.rd_data, 8'h00);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(i));
    idle_cycle();

    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, ADDR_W'(i), 8'(8'h11 + i), 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 4'd0, 8'hEE, 1'b0, '0);
    check_output("model_clr_drop", mem_m[0], 8'h00);
    set_inputs(1'b0, 1'b0, '0, '0, 1'b1, 4'd2);
    count_not_ready("ready_after_clr", DEPTH);
    set_inputs(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(i));
    idle_cycle();

    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
    set_inputs(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_flush_b_valid", bus_b.rd_valid, 1'b0);
    check_output("rst_flush_a_valid", bus_a.rd_valid, 1'b0);
    check_output("rst_flush_a_data", bus_a.rd_data, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    count_not_ready("ready_after_rerst", DEPTH);

    for (int n = 0; n < 600; n++) begin
      apply_stimulus(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                     ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                     1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)));
    end
    repeat (3) idle_cycle();
    check_output("drain_a", q_a.size(), 0);
    check_output("drain_b", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
